mips_controller: RTL and testbench
==================================

# mips_controller

Control unit for the multicycle MIPS datapath. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It combines this with a combinational ALU decoder and PC-enable logic. It drives every datapath mux select and write enable from the current state, the opcode, funct and the ALU zero flag.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces state to FETCH immediately.
- op  in  6  instruction opcode (instr[31:26]).
- funct  in  6  instruction funct field (instr[5:0]).
- zero  in  1  ALU result-is-zero flag.
- irwrite  out  1  instruction register write enable.
- memwrite  out  1  memory write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- pcen  out  1  PC register write enable.
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- alusrcb  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register.
- regwrite  out  1  register file write enable.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg  out  1  write-back source: 0 = ALUOut, 1 = memory data.
- bne_sign  out  1  asserted in BNE execute state.

## Operation
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
- Internal signals are pcwrite, branch and aluop[1:0]. Any output not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Always goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - LW/SW go to MEMADR.
  - RTYPE goes to RTYPEEX.
  - BEQ goes to BEQEX.
  - BNE goes to BNEEX.
  - ADDI goes to ADDIEX.
  - J goes to JEX.
  - Any other op goes to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW goes to MEMRD; SW goes to MEMWR.
- MEMRD: iord=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10, then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then FETCH.
- BNEEX: same outputs as BEQEX plus bne_sign=1, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JEX: pcsrc=10, pcwrite=1, then FETCH.
- pcen = pcwrite | (branch & (zero XOR bne_sign)). It is combinational in zero.
- ALU decoder (combinational):
  - aluop 00 gives 010.
  - aluop 01 gives 110.
  - aluop 10 decodes funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111, any other funct gives 010.
  - aluop 11 gives 010.

## Timing
- State register updates on the rising clk edge. All outputs except pcen and alucontrol are functions of state only.
- Reset is asynchronous: reset=0 forces FETCH regardless of clk. Outputs then equal FETCH values: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0.
- The first FETCH completes on the first rising edge after reset returns to 1.
- Cycles per instruction: LW 5; SW, RTYPE and ADDI 4; BEQ, BNE and J 3.
- Reset asserted mid-instruction abandons it and returns to FETCH with no further write enables.
- An undefined opcode costs 2 cycles (FETCH, DECODE) with no register or memory write.

## Test plan
- Hold reset=0 for 2 edges, then release → FETCH outputs: irwrite=1, pcen=1, alusrcb=01, alucontrol=010. Next cycle DECODE: alusrcb=11, irwrite=0, pcen=0.
- op=100011 → sequence FETCH, DECODE, MEMADR (alusrca=1, alusrcb=10), MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1), then FETCH. op=101011 ends in MEMWR with memwrite=1, iord=1 after 4 cycles.
- op=000000 with funct 100000, 100010, 100100, 100101, 101010 → in RTYPEEX, alucontrol is 010, 110, 000, 001, 111 respectively. RTYPEWB has regdst=1, regwrite=1.
- op=000100 in BEQEX: zero=1 gives pcen=1, pcsrc=01, alucontrol=110; zero=0 gives pcen=0. op=000101 in BNEEX: bne_sign=1, and pcen is 1 only when zero=0.
- op=001000 → ADDIEX (alusrcb=10, alucontrol=010), then ADDIWB (regwrite=1, regdst=0). op=000010 → JEX with pcsrc=10, pcen=1.
- Undefined op=111111 → DECODE then FETCH with no regwrite or memwrite. Asserting reset during MEMRD immediately produces FETCH outputs with iord=0.

Source files
------------

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore sequencer for the datapath plus the
// combinational ALU decoder and PC-enable logic.
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       irwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [1:0] alusrcb,
  output logic       alusrca,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       bne_sign
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    BNEEX,
    ADDIEX,
    ADDIWB,
    JEX
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_BNE:       next_state = BNEEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   next_state = MEMWB;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    irwrite  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    alusrcb  = 2'b00;
    alusrca  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    bne_sign = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch   = 1'b1;
        bne_sign = (state == BNEEX);
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        irwrite = 1'b0;
      end
    endcase
  end

  // BNE reuses the BEQ path; bne_sign inverts the sense of the zero test.
  always_comb begin
    pcen = pcwrite | (branch & (zero ^ bne_sign));
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: per-instruction step lists from the opcode rules,
// compared cycle by cycle against the packed control outputs.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       irwrite, memwrite, iord, pcen, alusrca, regwrite, regdst, memtoreg, bne_sign;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [15:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .irwrite(irwrite), .memwrite(memwrite), .iord(iord), .pcen(pcen),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .alusrcb(alusrcb), .alusrca(alusrca),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .bne_sign(bne_sign)
  );

  always #5 clk = ~clk;

  assign dut_vec = {irwrite, memwrite, iord, pcen, pcsrc, alucontrol, alusrcb,
                    alusrca, regwrite, regdst, memtoreg, bne_sign};

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control word for a named step, straight from the step table.
  function automatic logic [15:0] expect_vec(input string kind, input logic z, input logic [5:0] f);
    logic irw = 0, mw = 0, ird = 0, pce = 0, srca = 0, rw = 0, rdst = 0, m2r = 0, bne = 0;
    logic [1:0] psrc = 2'b00, srcb = 2'b00;
    logic [2:0] aluc = 3'b010;
    if (kind == "FETCH") begin irw = 1; pce = 1; srcb = 2'b01; end
    else if (kind == "DECODE") srcb = 2'b11;
    else if (kind == "MEMADR") begin srca = 1; srcb = 2'b10; end
    else if (kind == "MEMRD") ird = 1;
    else if (kind == "MEMWB") begin m2r = 1; rw = 1; end
    else if (kind == "MEMWR") begin ird = 1; mw = 1; end
    else if (kind == "RTYPEEX") begin srca = 1; aluc = rtype_alu(f); end
    else if (kind == "RTYPEWB") begin rdst = 1; rw = 1; end
    else if (kind == "BEQEX") begin srca = 1; aluc = 3'b110; psrc = 2'b01; pce = z; end
    else if (kind == "BNEEX") begin srca = 1; aluc = 3'b110; psrc = 2'b01; pce = !z; bne = 1; end
    else if (kind == "ADDIEX") begin srca = 1; srcb = 2'b10; end
    else if (kind == "ADDIWB") rw = 1;
    else if (kind == "JEX") begin psrc = 2'b10; pce = 1; end
    return {irw, mw, ird, pce, psrc, aluc, srcb, srca, rw, rdst, m2r, bne};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (op=%b funct=%b zero=%b)",
               tag, got, exp, op, funct, zero);
    end
  endtask

  // Runs one whole instruction; entered and left at a falling edge in FETCH.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f);
    string steps[$];
    op = o;
    funct = f;
    steps.push_back("FETCH");
    steps.push_back("DECODE");
    case (o)
      6'b100011: begin steps.push_back("MEMADR"); steps.push_back("MEMRD"); steps.push_back("MEMWB"); end
      6'b101011: begin steps.push_back("MEMADR"); steps.push_back("MEMWR"); end
      6'b000000: begin steps.push_back("RTYPEEX"); steps.push_back("RTYPEWB"); end
      6'b000100: steps.push_back("BEQEX");
      6'b000101: steps.push_back("BNEEX");
      6'b001000: begin steps.push_back("ADDIEX"); steps.push_back("ADDIWB"); end
      6'b000010: steps.push_back("JEX");
      default: ;
    endcase
    foreach (steps[i]) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      checkOutput(steps[i], dut_vec, expect_vec(steps[i], zero, f));
      @(negedge clk);
    end
  endtask

  logic [5:0] defined_ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b000101, 6'b001000, 6'b000010};
  logic [5:0] rtype_functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] o, f;
    int pick;
    #1;
    checkOutput("reset_low", dut_vec, expect_vec("FETCH", zero, funct));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", dut_vec, expect_vec("FETCH", zero, funct));
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(6'b100011, 6'b0);
    applyStimulus(6'b101011, 6'b0);
    foreach (rtype_functs[i]) applyStimulus(6'b000000, rtype_functs[i]);
    applyStimulus(6'b000000, 6'b111111);
    repeat (3) applyStimulus(6'b000100, 6'b0);
    repeat (3) applyStimulus(6'b000101, 6'b0);
    applyStimulus(6'b001000, 6'b0);
    applyStimulus(6'b000010, 6'b0);
    applyStimulus(6'b111111, 6'b0);

    // Reset dropped in the middle of a load must abandon it at once.
    op = 6'b100011;
    funct = 6'b0;
    foreach (defined_ops[i]) begin
      if (i < 3) begin
        #1;
        checkOutput(i == 0 ? "abort_fetch" : (i == 1 ? "abort_decode" : "abort_memadr"),
                    dut_vec, expect_vec(i == 0 ? "FETCH" : (i == 1 ? "DECODE" : "MEMADR"), zero, funct));
        @(negedge clk);
      end
    end
    #1;
    checkOutput("abort_memrd", dut_vec, expect_vec("MEMRD", zero, funct));
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset_in_memrd", dut_vec, expect_vec("FETCH", zero, funct));
    @(posedge clk);
    #1;
    checkOutput("reset_in_memrd_hold", dut_vec, expect_vec("FETCH", zero, funct));
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 7);
      if (pick == 7) begin
        o = 6'($urandom);
        while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010})
          o = 6'($urandom);
      end else begin
        o = defined_ops[pick];
      end
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rtype_functs[$urandom_range(0, 4)];
      applyStimulus(o, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
